// File: rtl/hr_pkg.sv
// hr_pkg: shared acquisition state encoding and default timing constants
package hr_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_TICK, REQ, WAIT_DONE, LOAD, VALID} state_e;
  localparam int TICK_DIV_DEF = 50000;
  localparam int TIMEOUT_DEF  = 255;
  localparam int CW_DEF       = 16;
endpackage

// File: rtl/sample_sched_tick_gen.sv
// tick_gen: free-running sample-period divider with synchronous clear and one-cycle tick
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q;
  assign tick_o = !clr_i && cnt_q == W'(DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/sample_sched.sv
// sample_sched: heart-rate ADC acquisition scheduler with conversion timeout and valid/ready output
module sample_sched
  import hr_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          conv_done,
  input  logic          out_ready,
  input  logic          clr_err,
  output logic          conv_req,
  output logic          load_en,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun,
  output logic          timeout_err,
  output logic [CW-1:0] sample_cnt
);
  localparam int TW = $clog2(TIMEOUT);
  state_e        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, overrun_d, timeout_q, timeout_d;
  logic          tick, expire, hs;

  tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .clr_i(!run), .tick_o(tick));

  assign expire = state_q == WAIT_DONE && !conv_done && to_cnt_q == TW'(TIMEOUT - 1);
  assign hs     = state_q == VALID && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = run ? WAIT_TICK : IDLE;
      WAIT_TICK: state_d = !run ? IDLE : tick ? REQ : WAIT_TICK;
      REQ:       state_d = WAIT_DONE;
      WAIT_DONE: state_d = conv_done ? LOAD : !expire ? WAIT_DONE : run ? WAIT_TICK : IDLE;
      LOAD:      state_d = VALID;
      VALID:     state_d = !out_ready ? VALID : tick ? REQ : run ? WAIT_TICK : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // a tick landing on the VALID handshake is consumed directly, so it is not an overrun
  always_comb begin
    to_cnt_d  = state_q == REQ ? '0 : state_q == WAIT_DONE ? to_cnt_q + 1'b1 : to_cnt_q;
    cnt_d     = cnt_q + CW'(hs);
    overrun_d = (tick && state_q != WAIT_TICK && !hs) || (overrun_q && !clr_err);
    timeout_d = expire || (timeout_q && !clr_err);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end

  assign conv_req    = state_q == REQ;
  assign load_en     = state_q == LOAD;
  assign out_valid   = state_q == VALID;
  assign busy        = state_q != IDLE;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;
  assign sample_cnt  = cnt_q;
endmodule

// File: tb/tb_sample_sched.sv
// tb_sample_sched: table-driven scenarios plus load_en scoreboard for sample_sched
module tb_sample_sched;
  typedef struct {
    int   done_dly;
    int   rdy_hold;
    int   exp_gap;
    logic exp_to;
    logic exp_ovr;
  } vec_t;

  logic clk = 0, rst = 1, run = 0, conv_done = 0, out_ready = 1, clr_err = 0;
  logic conv_req, load_en, out_valid, busy, overrun, timeout_err;
  logic [3:0] sample_cnt;
  int cyc = 0, checks = 0, errors = 0;
  int exp_load[$];
  logic [3:0] exp_cnt = 0;
  logic ld_prev = 0, ov_prev = 0;
  vec_t tbl[10];

  sample_sched #(.TICK_DIV(10), .TIMEOUT(4), .CW(4)) dut (
    .clk(clk), .rst(rst), .run(run), .conv_done(conv_done), .out_ready(out_ready),
    .clr_err(clr_err), .conv_req(conv_req), .load_en(load_en), .out_valid(out_valid),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      exp_load.delete();
      ld_prev = 0;
      ov_prev = 0;
    end else begin
      chk("sample_cnt", int'(sample_cnt), int'(exp_cnt));
      if (exp_load.size() != 0 && exp_load[0] < cyc) begin
        chk("load_en_missing", cyc, exp_load[0]);
        void'(exp_load.pop_front());
      end
      if (load_en) begin
        chk("load_en_cycle", cyc, exp_load.size() != 0 ? exp_load[0] : -1);
        if (exp_load.size() != 0) void'(exp_load.pop_front());
      end
      if (ld_prev || (out_valid && !ov_prev))
        chk("valid_after_load", int'(out_valid && !ov_prev), int'(ld_prev));
      if (out_valid && out_ready) exp_cnt = exp_cnt + 4'd1;
      ld_prev = load_en;
      ov_prev = out_valid;
    end
  end

  task automatic wait_req(input int exp_k, input string nm);
    int k = 0;
    do begin
      step();
      k++;
    end while (!conv_req && k < 40);
    chk(nm, k, exp_k);
  endtask

  task automatic run_vec(input int i);
    vec_t v = tbl[i];
    int   k = 0, hold = 0;
    logic seen = 0;
    do begin
      step();
      k++;
      clr_err = 0;
      if (!conv_req) begin
        if (k == 1) chk($sformatf("vec%0d_busy", i), int'(busy), 1);
        if (v.exp_to && k == 4) chk($sformatf("vec%0d_to_early", i), int'(timeout_err), 0);
        if (v.exp_to && k == 5) chk($sformatf("vec%0d_to_set", i), int'(timeout_err), 1);
        conv_done = (k == v.done_dly);
        if (conv_done && !v.exp_to) exp_load.push_back(cyc + 1);
        if (out_valid && !seen) begin
          seen = 1;
          hold = v.rdy_hold;
        end
        out_ready = (hold == 0);
        if (hold > 0) hold--;
      end
    end while (!conv_req && k < 60);
    chk($sformatf("vec%0d_req_gap", i), k, 10 * v.exp_gap);
    chk($sformatf("vec%0d_timeout_err", i), int'(timeout_err), int'(v.exp_to));
    chk($sformatf("vec%0d_overrun", i), int'(overrun), int'(v.exp_ovr));
    clr_err = 1;
  endtask

  initial begin
    int reqs;
    tbl[0] = '{2, 0, 1, 1'b0, 1'b0};
    tbl[1] = '{2, 0, 1, 1'b0, 1'b0};
    tbl[2] = '{3, 0, 1, 1'b0, 1'b0};
    tbl[3] = '{-1, 0, 1, 1'b1, 1'b0};
    tbl[4] = '{4, 0, 1, 1'b0, 1'b0};
    tbl[5] = '{5, 0, 1, 1'b1, 1'b0};
    tbl[6] = '{2, 20, 3, 1'b0, 1'b1};
    tbl[7] = '{2, 5, 1, 1'b0, 1'b0};
    tbl[8] = '{2, 6, 2, 1'b0, 1'b1};
    tbl[9] = '{1, 0, 1, 1'b0, 1'b0};

    step();
    step();
    chk("rst_conv_req", int'(conv_req), 0);
    chk("rst_load_en", int'(load_en), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    rst = 0;
    step();
    step();
    chk("idle_busy", int'(busy), 0);

    run = 1;
    wait_req(10, "first_req");
    clr_err = 1;
    foreach (tbl[i]) run_vec(i);

    step();
    clr_err = 0;
    run = 0;
    step();
    conv_done = 1;
    exp_load.push_back(cyc + 1);
    step();
    conv_done = 0;
    step();
    chk("drop_valid", int'(out_valid), 1);
    step();
    chk("drop_busy", int'(busy), 0);
    chk("drop_out_valid", int'(out_valid), 0);
    reqs = 0;
    repeat (25) begin
      step();
      reqs += int'(conv_req);
    end
    chk("drop_no_req", reqs, 0);

    run = 1;
    wait_req(10, "restart_req");
    step();
    step();
    conv_done = 1;
    exp_load.push_back(cyc + 1);
    step();
    conv_done = 0;
    out_ready = 0;
    repeat (7) step();
    chk("stall_out_valid", int'(out_valid), 1);
    chk("stall_overrun", int'(overrun), 1);
    rst = 1;
    #1;
    chk("async_conv_req", int'(conv_req), 0);
    chk("async_load_en", int'(load_en), 0);
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_overrun", int'(overrun), 0);
    chk("async_timeout_err", int'(timeout_err), 0);
    chk("async_sample_cnt", int'(sample_cnt), 0);
    step();
    step();
    out_ready = 1;
    rst = 0;
    wait_req(10, "post_reset_req");
    for (int n = 0; n < 16; n++) begin
      run_vec(0);
      if (n == 14) chk("cnt_15", int'(sample_cnt), 15);
    end
    chk("cnt_wrap", int'(sample_cnt), 0);
    chk("load_queue_empty", exp_load.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
